sd_cmd_tx: RTL and testbench

Command-line transmitter for the SD host controller. It accepts a command index and a 32-bit argument and sends the 40-bit prefix {start, tx, index, arg} to an external crc7 #(40) instance. It waits for that instance's CRC, assembles the 48-bit SD command frame, and shifts the frame MSB-first onto the CMD line, one bit per bit_en tick. It sits directly downstream of crc7 and consumes its crc/crc_ready outputs.

---
 rtl/sd_cmd_tx.sv | 208 ++++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_tx
// Description : SD command-line transmitter. Accepts a command index and a
//               32-bit argument, presents the 40-bit prefix {01, index, arg}
//               to an external crc7 instance, waits for its CRC, then shifts
//               the 48-bit frame {prefix, crc, 1} MSB-first onto the CMD
//               line, one bit per bit_en tick.
// Ports       :
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   cmd_valid  - command request (handshake with cmd_ready)
//   cmd_ready  - high only when idle
//   cmd_index  - 6-bit command index, captured at transfer
//   cmd_arg    - 32-bit command argument, captured at transfer
//   bit_en     - one-clk tick per SD bit period
//   crc_load   - one-cycle load strobe to crc7
//   crc_data   - 40-bit prefix to crc7, stable until CRC capture
//   crc_ready  - crc7 completion flag
//   crc        - crc7 result, valid while crc_ready is high
//   sd_cmd_out - serial CMD line data
//   sd_cmd_oe  - CMD line drive enable (0 = released / pulled high)
//   tx_done    - one-cycle pulse after the frame has been released
//   tx_error   - one-cycle pulse when the CRC wait times out
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_tx #(
    parameter int CRC_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        bit_en,
    output logic        crc_load,
    output logic [39:0] crc_data,
    input  logic        crc_ready,
    input  logic [6:0]  crc,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        tx_done,
    output logic        tx_error
);

    localparam int              c_TO_W     = $clog2(CRC_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(CRC_TIMEOUT);
    localparam logic [5:0]      c_LAST_BIT = 6'd47;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CRC_WAIT = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [39:0]         r_crc_data;
    logic [47:0]         r_frame;
    logic [5:0]          r_bit_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_cmd_out;
    logic                r_cmd_oe;
    logic                r_tx_done;
    logic                r_tx_error;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [39:0]         w_crc_data_nxt;
    logic [47:0]         w_frame_nxt;
    logic [5:0]          w_bit_cnt_nxt;
    logic [c_TO_W-1:0]   w_to_cnt_nxt;
    logic [c_TO_W-1:0]   w_to_cnt_inc;
    logic                w_cmd_out_nxt;
    logic                w_cmd_oe_nxt;
    logic                w_tx_done_nxt;
    logic                w_tx_error_nxt;
    logic                w_cmd_ready;
    logic                w_crc_load;
    logic [5:0]          w_bit_idx;

    assign w_to_cnt_inc = r_to_cnt + 1'b1;
    // Frame is sent MSB first: count 0 selects bit 47 (start bit).
    assign w_bit_idx    = c_LAST_BIT - r_bit_cnt;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_crc_data_nxt = r_crc_data;
        w_frame_nxt    = r_frame;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_cmd_out_nxt  = r_cmd_out;
        w_cmd_oe_nxt   = r_cmd_oe;
        w_tx_done_nxt  = 1'b0;
        w_tx_error_nxt = 1'b0;
        w_cmd_ready    = 1'b0;
        w_crc_load     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_crc_data_nxt = {2'b01, cmd_index, cmd_arg};
                    w_state_nxt    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_crc_load   = 1'b1;
                w_to_cnt_nxt = '0;
                w_state_nxt  = ST_CRC_WAIT;
            end

            ST_CRC_WAIT: begin
                // A zero count marks the first wait cycle; crc_ready there may
                // still belong to the previous command, so it is not trusted.
                if ((r_to_cnt != '0) && crc_ready) begin
                    w_frame_nxt   = {r_crc_data, crc, 1'b1};
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end else if (w_to_cnt_inc == c_TO_LIMIT) begin
                    w_tx_error_nxt = 1'b1;
                    w_cmd_oe_nxt   = 1'b0;
                    w_cmd_out_nxt  = 1'b1;
                    w_to_cnt_nxt   = '0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = w_to_cnt_inc;
                end
            end

            ST_SHIFT: begin
                if (bit_en) begin
                    w_cmd_oe_nxt  = 1'b1;
                    w_cmd_out_nxt = r_frame[w_bit_idx];
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
            end

            ST_FINISH: begin
                // The end bit stays on the line for one full bit period.
                if (bit_en) begin
                    w_cmd_oe_nxt  = 1'b0;
                    w_cmd_out_nxt = 1'b1;
                    w_tx_done_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: begin
                w_cmd_oe_nxt  = 1'b0;
                w_cmd_out_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_crc_data <= '0;
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_crc_data <= w_crc_data_nxt;
            r_frame    <= w_frame_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_cmd_out  <= w_cmd_out_nxt;
            r_cmd_oe   <= w_cmd_oe_nxt;
            r_tx_done  <= w_tx_done_nxt;
            r_tx_error <= w_tx_error_nxt;
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign crc_load   = w_crc_load;
    assign crc_data   = r_crc_data;
    assign sd_cmd_out = r_cmd_out;
    assign sd_cmd_oe  = r_cmd_oe;
    assign tx_done    = r_tx_done;
    assign tx_error   = r_tx_error;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_tx
// Description : Directed testbench for sd_cmd_tx. The bench plays the role of
//               crc7 and of the SD clock divider, collects the serial frame
//               and compares it against hand-computed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_tx;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        bit_en;
    logic        crc_load;
    logic [39:0] crc_data;
    logic        crc_ready;
    logic [6:0]  crc;
    logic        sd_cmd_out;
    logic        sd_cmd_oe;
    logic        tx_done;
    logic        tx_error;

    int n_checks = 0;
    int n_fail   = 0;

    sd_cmd_tx #(.CRC_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .bit_en     (bit_en),
        .crc_load   (crc_load),
        .crc_data   (crc_data),
        .crc_ready  (crc_ready),
        .crc        (crc),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full command. pre: the transfer already happened on the previous
    // edge. abort_after: nonzero = assert reset after that many bits.
    task automatic run_cmd(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crcv, input logic [47:0] exp_frame,
                           input int period, input bit stale, input bit ben_cap,
                           input bit hold_valid, input bit pre, input int abort_after);
        logic [47:0] got;
        logic        last;
        int          oe_bits;
        int          hold_err;
        int          load_seen;
        got       = '0;
        last      = 1'b1;
        oe_bits   = 0;
        hold_err  = 0;
        load_seen = 0;

        if (!pre) begin
            chk({nm, "_ready_idle"}, cmd_ready, 1'b1);
            cmd_valid = 1'b1;
            cmd_index = idx;
            cmd_arg   = arg;
            if (stale) begin
                crc_ready = 1'b1;
                crc       = ~crcv;
            end
            tick();
        end
        if (!hold_valid) begin
            cmd_valid = 1'b0;
            cmd_index = ~idx;
            cmd_arg   = ~arg;
        end
        chk({nm, "_crc_load"}, crc_load, 1'b1);
        chk({nm, "_crc_data"}, crc_data, exp_frame[47:8]);
        chk({nm, "_ready_busy"}, cmd_ready, 1'b0);
        if (!stale) crc_ready = 1'b0;
        tick();                      // first CRC_WAIT cycle
        chk({nm, "_load_once"}, crc_load, 1'b0);
        tick();                      // second CRC_WAIT cycle
        crc       = crcv;
        crc_ready = 1'b1;
        bit_en    = ben_cap;
        tick();                      // capture edge
        bit_en    = 1'b0;
        chk({nm, "_oe_at_capture"}, sd_cmd_oe, 1'b0);

        for (int b = 0; b < 48; b++) begin
            repeat (period - 1) begin
                tick();
                if (sd_cmd_out !== last || sd_cmd_oe !== (b > 0) || tx_done !== 1'b0
                    || cmd_ready !== 1'b0 || tx_error !== 1'b0)
                    hold_err++;
                if (crc_load) load_seen++;
            end
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            got  = {got[46:0], sd_cmd_out};
            last = sd_cmd_out;
            if (sd_cmd_oe === 1'b1) oe_bits++;
            if (tx_done !== 1'b0 || cmd_ready !== 1'b0) hold_err++;
            if (crc_load) load_seen++;
            if (abort_after == b + 1) begin
                chk({nm, "_partial_bits"}, got[19:0], exp_frame[47:28]);
                #2 rst_n = 1'b0;
                #1;
                chk({nm, "_rst_oe"}, sd_cmd_oe, 1'b0);
                chk({nm, "_rst_out"}, sd_cmd_out, 1'b1);
                chk({nm, "_rst_ready"}, cmd_ready, 1'b1);
                tick();
                rst_n = 1'b1;
                tick();
                chk({nm, "_post_rst_ready"}, cmd_ready, 1'b1);
                chk({nm, "_post_rst_oe"}, sd_cmd_oe, 1'b0);
                return;
            end
        end
        chk({nm, "_frame"}, got, exp_frame);
        chk({nm, "_oe_bits"}, oe_bits, 48);
        chk({nm, "_hold_errs"}, hold_err, 0);
        chk({nm, "_extra_loads"}, load_seen, 0);

        hold_err = 0;
        repeat (period - 1) begin
            tick();
            if (sd_cmd_oe !== 1'b1 || sd_cmd_out !== 1'b1 || tx_done !== 1'b0) hold_err++;
        end
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        chk({nm, "_end_hold"}, hold_err, 0);
        chk({nm, "_tx_done"}, tx_done, 1'b1);
        chk({nm, "_release_oe"}, sd_cmd_oe, 1'b0);
        chk({nm, "_release_out"}, sd_cmd_out, 1'b1);
        chk({nm, "_ready_after"}, cmd_ready, 1'b1);
        chk({nm, "_no_error"}, tx_error, 1'b0);
        tick();
        chk({nm, "_done_pulse"}, tx_done, 1'b0);
        if (hold_valid)
            chk({nm, "_next_accept"}, crc_load, 1'b1);
        else
            chk({nm, "_stay_idle"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int err_at;
        int errs;
        int dones;
        int oe_bad;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        bit_en    = 1'b0;
        crc_ready = 1'b0;
        crc       = '0;
        repeat (3) tick();

        chk("rst_ready",    cmd_ready,  1'b1);
        chk("rst_crc_load", crc_load,   1'b0);
        chk("rst_crc_data", crc_data,   40'h0);
        chk("rst_out",      sd_cmd_out, 1'b1);
        chk("rst_oe",       sd_cmd_oe,  1'b0);
        chk("rst_done",     tx_done,    1'b0);
        chk("rst_error",    tx_error,   1'b0);
        rst_n = 1'b1;
        tick();

        // CMD0, bit_en every cycle
        run_cmd("cmd0", 6'd0, 32'h0, 7'b1001010, 48'h40_0000_0000_95, 1, 0, 0, 0, 0, 0);
        // CMD17, bit_en every 2nd cycle, bit_en coinciding with capture
        run_cmd("cmd17", 6'd17, 32'h0, 7'b0101010, 48'h51_0000_0000_55, 2, 0, 1, 0, 0, 0);
        // Stale crc_ready (with a wrong crc) held across the command start
        run_cmd("stale", 6'd8, 32'h0000_01AA, 7'h43, 48'h48_0000_01AA_87, 1, 1, 0, 0, 0, 0);

        // CRC timeout: crc_ready never rises; CRC_TIMEOUT = 8
        crc_ready = 1'b0;
        chk("to_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_index = 6'd5;
        cmd_arg   = 32'h1234_5678;
        tick();                      // transfer edge = cycle 1
        cmd_valid = 1'b0;
        err_at = -1;
        errs   = 0;
        dones  = 0;
        oe_bad = 0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (tx_error === 1'b1) begin
                errs++;
                if (err_at < 0) err_at = c;
            end
            if (tx_done !== 1'b0) dones++;
            if (sd_cmd_oe !== 1'b0) oe_bad++;
        end
        chk("to_error_cycle", err_at, 10);
        chk("to_error_pulses", errs, 1);
        chk("to_no_done", dones, 0);
        chk("to_oe_low", oe_bad, 0);
        chk("to_ready_after", cmd_ready, 1'b1);

        // Reset after the 20th bit, then a clean CMD0
        run_cmd("abort", 6'd0, 32'h0, 7'b1001010, 48'h40_0000_0000_95, 1, 0, 0, 0, 0, 20);
        run_cmd("cmd0b", 6'd0, 32'h0, 7'b1001010, 48'h40_0000_0000_95, 1, 0, 0, 0, 0, 0);

        // cmd_valid held during a sparse-tick transfer; second command follows tx_done
        run_cmd("busy1", 6'd55, 32'hDEAD_BEEF, 7'h5A, 48'h77_DEAD_BEEF_B5, 4, 0, 0, 1, 0, 0);
        run_cmd("busy2", 6'd55, 32'hDEAD_BEEF, 7'h5A, 48'h77_DEAD_BEEF_B5, 4, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
